// File: rtl/music_pkg.sv
// Shared score-entry layout, sequencer states and entry decode helpers for the music design.
// Pure declarations: no logic, no latency, no flow control.
package music_pkg;

  localparam int NOTE_HI  = 15;
  localparam int NOTE_LO  = 9;
  localparam int REST_BIT = 8;
  localparam int DUR_W    = 8;
  localparam int NOTE_W   = NOTE_HI - NOTE_LO + 1;

  localparam logic [DUR_W-1:0] END_DUR = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_END
  } state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic              rest;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  function automatic entry_t decode_entry(input logic [15:0] word);
    entry_t e;
    e.note = word[NOTE_HI:NOTE_LO];
    e.rest = word[REST_BIT];
    e.dur  = word[DUR_W-1:0];
    return e;
  endfunction

  function automatic logic is_end_marker(input entry_t e);
    return e.dur == END_DUR;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Tempo prescaler: one-cycle registered tick every TICK_DIV cycles, phase restarted by restart.
// The first tick after a restart is seen exactly TICK_DIV cycles after the restart edge; never stalls.
module tick_gen #(
  parameter int TICK_DIV = 750000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  // tick is registered, so it is raised one count early to land on the wrap edge
  localparam logic [CW-1:0] PRE  = CW'(TICK_DIV - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
      tick <= (cnt == PRE);
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Score player: walks the note ROM and issues timed on/off/done strobes to the tone generator.
// First strobe 3 cycles after start; following entries are prefetched so strobes never slip.
module note_sequencer
  import music_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int TICK_DIV = 750000,
  parameter int ARTIC    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              on,
  output logic              off,
  output logic [NOTE_W-1:0] note,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state, state_d;
  logic [ADDR_W-1:0] rom_addr_d;
  logic              on_d, off_d, done_d, busy_d;
  logic [NOTE_W-1:0] note_d;
  logic [DUR_W-1:0]  remaining, remaining_d;
  entry_t            hold, hold_d;
  logic [1:0]        pf_cnt, pf_cnt_d;
  logic              wrap_pend, wrap_pend_d;
  logic              cur_rest, cur_rest_d;
  logic              loop_q, loop_q_d;

  logic              restart;
  logic              tick;
  entry_t            rom_e;
  logic              commit;
  entry_t            commit_e;
  logic              commit_end;

  assign rom_e = decode_entry(rom_data);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    state_d     = state;
    rom_addr_d  = rom_addr;
    on_d        = 1'b0;
    off_d       = 1'b0;
    done_d      = 1'b0;
    note_d      = note;
    remaining_d = remaining;
    hold_d      = hold;
    pf_cnt_d    = pf_cnt;
    wrap_pend_d = wrap_pend;
    cur_rest_d  = cur_rest;
    loop_q_d    = loop_q;
    restart     = 1'b0;
    commit      = 1'b0;
    commit_e    = rom_e;
    commit_end  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_d     = S_FETCH;
          rom_addr_d  = '0;
          wrap_pend_d = 1'b0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        commit     = 1'b1;
        commit_e   = rom_e;
        commit_end = is_end_marker(rom_e);
      end
      S_PLAY: begin
        // ROM word for the address bumped at commit is valid on the second PLAY cycle
        if (pf_cnt == 2'd1) hold_d = rom_e;
        if (pf_cnt != 2'd2) pf_cnt_d = pf_cnt + 2'd1;
        if (tick) begin
          if (remaining == DUR_W'(1)) begin
            commit     = 1'b1;
            commit_e   = hold;
            commit_end = wrap_pend || is_end_marker(hold);
          end else begin
            remaining_d = remaining - 1'b1;
            if ((ARTIC != 0) && (remaining == DUR_W'(2)) && !cur_rest) off_d = 1'b1;
          end
        end
      end
      S_END: begin
        rom_addr_d = '0;
        if (loop_q) begin
          state_d     = S_FETCH;
          wrap_pend_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      if (commit_end) begin
        state_d  = S_END;
        loop_q_d = loop;
        if (!loop) begin
          off_d  = 1'b1;
          done_d = 1'b1;
        end
      end else begin
        state_d     = S_PLAY;
        remaining_d = commit_e.dur;
        restart     = 1'b1;
        pf_cnt_d    = 2'd0;
        cur_rest_d  = commit_e.rest;
        // the entry after the last ROM address counts as an end marker
        wrap_pend_d = (rom_addr == ADDR_MAX);
        rom_addr_d  = rom_addr + 1'b1;
        if (commit_e.rest) begin
          off_d = 1'b1;
        end else begin
          on_d   = 1'b1;
          note_d = commit_e.note;
        end
      end
    end

    if (stop && (state != S_IDLE)) begin
      state_d    = S_IDLE;
      rom_addr_d = '0;
      on_d       = 1'b0;
      off_d      = 1'b1;
      done_d     = 1'b0;
      restart    = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rom_addr  <= '0;
      on        <= 1'b0;
      off       <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      note      <= '0;
      remaining <= '0;
      hold      <= '0;
      pf_cnt    <= 2'd0;
      wrap_pend <= 1'b0;
      cur_rest  <= 1'b0;
      loop_q    <= 1'b0;
    end else begin
      state     <= state_d;
      rom_addr  <= rom_addr_d;
      on        <= on_d;
      off       <= off_d;
      done      <= done_d;
      busy      <= busy_d;
      note      <= note_d;
      remaining <= remaining_d;
      hold      <= hold_d;
      pf_cnt    <= pf_cnt_d;
      wrap_pend <= wrap_pend_d;
      cur_rest  <= cur_rest_d;
      loop_q    <= loop_q_d;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: three instances (plain, articulated, 2-bit address) with behavioural ROMs.
// Strobes are matched against a scoreboard of expected (cycle, kind, note) events.
module tb_note_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stop, loop;
  logic start_a, start_b, start_c;
  logic [5:0]  addr_a, addr_b;
  logic [1:0]  addr_c;
  logic [15:0] data_a, data_b, data_c;
  logic [15:0] rom_a [64];
  logic [15:0] rom_b [64];
  logic [15:0] rom_c [4];
  logic on_a, off_a, done_a, busy_a;
  logic on_b, off_b, done_b, busy_b;
  logic on_c, off_c, done_c, busy_c;
  logic [6:0] note_a, note_b, note_c;

  always @(posedge clk) begin
    data_a <= rom_a[addr_a];
    data_b <= rom_b[addr_b];
    data_c <= rom_c[addr_c];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  note_sequencer #(.ADDR_W(6), .TICK_DIV(4), .ARTIC(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop), .loop(loop),
    .rom_addr(addr_a), .rom_data(data_a), .on(on_a), .off(off_a),
    .note(note_a), .busy(busy_a), .done(done_a));

  note_sequencer #(.ADDR_W(6), .TICK_DIV(4), .ARTIC(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop), .loop(loop),
    .rom_addr(addr_b), .rom_data(data_b), .on(on_b), .off(off_b),
    .note(note_b), .busy(busy_b), .done(done_b));

  note_sequencer #(.ADDR_W(2), .TICK_DIV(4), .ARTIC(0)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .stop(stop), .loop(loop),
    .rom_addr(addr_c), .rom_data(data_c), .on(on_c), .off(off_c),
    .note(note_c), .busy(busy_c), .done(done_c));

  typedef struct {
    int         lbl;
    logic       on;
    logic       off;
    logic       done;
    logic [6:0] note;
  } ev_t;

  typedef struct {
    logic       start;
    logic       stop;
    logic       exp_busy;
    logic       exp_on;
    logic       exp_off;
    logic [6:0] exp_note;
  } vec_t;

  ev_t  sb [$];
  vec_t vt [8];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sel      = 0;
  bit   mon_en   = 1'b0;
  int   t;

  function automatic logic [15:0] ent(input logic [6:0] n, input logic r, input logic [7:0] d);
    return {n, r, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Label of the cycle whose outputs are visible at this negedge is cyc+1.
  task automatic monitor();
    logic o_on, o_off, o_done;
    logic [6:0] o_note;
    ev_t e;
    case (sel)
      0:       begin o_on = on_a; o_off = off_a; o_done = done_a; o_note = note_a; end
      1:       begin o_on = on_b; o_off = off_b; o_done = done_b; o_note = note_b; end
      default: begin o_on = on_c; o_off = off_c; o_done = done_c; o_note = note_c; end
    endcase
    if (mon_en && (o_on || o_off || o_done)) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {32'(cyc + 1), o_on, o_off, o_done, o_note}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("strobe", {32'(cyc + 1), o_on, o_off, o_done, o_note},
              {32'(e.lbl), e.on, e.off, e.done, e.note});
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
  endtask

  task automatic push(input int lbl, input logic o, input logic f, input logic d, input logic [6:0] n);
    ev_t e;
    e.lbl = lbl; e.on = o; e.off = f; e.done = d; e.note = n;
    sb.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int b = 0;
    while (sb.size() > 0 && b < budget) begin
      step();
      b++;
    end
    check({name, "_pending"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic wait_label(input int lbl);
    int b = 0;
    while ((cyc + 1 < lbl) && b < 200) begin
      step();
      b++;
    end
  endtask

  task automatic clear_roms();
    for (int i = 0; i < 64; i++) begin
      rom_a[i] = 16'h0;
      rom_b[i] = 16'h0;
    end
    for (int i = 0; i < 4; i++) rom_c[i] = 16'h0;
  endtask

  initial begin
    rst = 1'b1; stop = 1'b0; loop = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    clear_roms();
    repeat (3) step();
    check("reset_a", {addr_a, on_a, off_a, done_a, busy_a, note_a}, 64'd0);
    check("reset_b_busy", busy_b, 1'b0);
    check("reset_c", {addr_c, on_c, off_c, done_c, busy_c}, 64'd0);
    rst = 1'b0;
    step();

    // cycle vectors: IDLE collisions, a start, then start+stop while playing
    rom_a[0] = ent(7'h11, 1'b0, 8'd5);
    vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00};
    vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00};
    vt[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00};
    vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00};
    vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'h11};
    vt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'h11};
    vt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h11};
    for (int i = 0; i < 8; i++) begin
      start_a = vt[i].start;
      stop    = vt[i].stop;
      step();
      start_a = 1'b0;
      stop    = 1'b0;
      check($sformatf("vec%0d", i), {busy_a, on_a, off_a, done_a, note_a},
            {vt[i].exp_busy, vt[i].exp_on, vt[i].exp_off, 1'b0, vt[i].exp_note});
    end
    repeat (4) step();
    mon_en = 1'b1;

    // basic playback
    sel = 0; clear_roms();
    rom_a[0] = ent(7'h4A, 1'b0, 8'd2);
    rom_a[1] = ent(7'h40, 1'b0, 8'd1);
    t = cyc + 1;
    push(t + 3,  1'b1, 1'b0, 1'b0, 7'h4A);
    push(t + 11, 1'b1, 1'b0, 1'b0, 7'h40);
    push(t + 15, 1'b0, 1'b1, 1'b1, 7'h40);
    start_a = 1'b1; step(); start_a = 1'b0;
    check("basic_busy_t1", busy_a, 1'b1);
    check("basic_addr_t1", addr_a, 6'd0);
    drain("basic", 40);
    check("basic_busy_last", busy_a, 1'b1);
    step();
    check("basic_busy_after", busy_a, 1'b0);
    repeat (4) step();

    // rest entry between two notes
    clear_roms();
    rom_a[0] = ent(7'h30, 1'b0, 8'd1);
    rom_a[1] = ent(7'h7F, 1'b1, 8'd3);
    rom_a[2] = ent(7'h35, 1'b0, 8'd1);
    t = cyc + 1;
    push(t + 3,  1'b1, 1'b0, 1'b0, 7'h30);
    push(t + 7,  1'b0, 1'b1, 1'b0, 7'h30);
    push(t + 19, 1'b1, 1'b0, 1'b0, 7'h35);
    push(t + 23, 1'b0, 1'b1, 1'b1, 7'h35);
    start_a = 1'b1; step(); start_a = 1'b0;
    drain("rest", 60);
    repeat (4) step();

    // articulation gap
    sel = 1; clear_roms();
    rom_b[0] = ent(7'h52, 1'b0, 8'd3);
    rom_b[1] = ent(7'h40, 1'b0, 8'd1);
    t = cyc + 1;
    push(t + 3,  1'b1, 1'b0, 1'b0, 7'h52);
    push(t + 11, 1'b0, 1'b1, 1'b0, 7'h52);
    push(t + 15, 1'b1, 1'b0, 1'b0, 7'h40);
    push(t + 19, 1'b0, 1'b1, 1'b1, 7'h40);
    start_b = 1'b1; step(); start_b = 1'b0;
    drain("artic", 60);
    repeat (4) step();

    // loop, then drop loop before the third end
    sel = 0; clear_roms();
    rom_a[0] = ent(7'h21, 1'b0, 8'd1);
    loop = 1'b1;
    t = cyc + 1;
    push(t + 3,  1'b1, 1'b0, 1'b0, 7'h21);
    push(t + 10, 1'b1, 1'b0, 1'b0, 7'h21);
    push(t + 17, 1'b1, 1'b0, 1'b0, 7'h21);
    push(t + 21, 1'b0, 1'b1, 1'b1, 7'h21);
    start_a = 1'b1; step(); start_a = 1'b0;
    wait_label(t + 18);
    loop = 1'b0;
    drain("loop", 40);
    step();
    check("loop_busy_after", busy_a, 1'b0);
    repeat (4) step();

    // start during PLAY is ignored, then stop mid-note
    clear_roms();
    rom_a[0] = ent(7'h11, 1'b0, 8'd5);
    t = cyc + 1;
    push(t + 3, 1'b1, 1'b0, 1'b0, 7'h11);
    start_a = 1'b1; step(); start_a = 1'b0;
    wait_label(t + 5);
    start_a = 1'b1; step(); start_a = 1'b0;
    wait_label(t + 8);
    push(cyc + 2, 1'b0, 1'b1, 1'b0, 7'h11);
    stop = 1'b1; step(); stop = 1'b0;
    check("stop_busy", busy_a, 1'b0);
    drain("stop", 10);
    repeat (30) step();

    // address wrap with no end marker
    sel = 2; clear_roms();
    for (int i = 0; i < 4; i++) rom_c[i] = ent(7'(i + 1), 1'b0, 8'd1);
    t = cyc + 1;
    for (int i = 0; i < 4; i++) push(t + 3 + 4 * i, 1'b1, 1'b0, 1'b0, 7'(i + 1));
    push(t + 19, 1'b0, 1'b1, 1'b1, 7'h04);
    start_c = 1'b1; step(); start_c = 1'b0;
    drain("wrap", 40);
    step();
    check("wrap_busy_after", busy_c, 1'b0);
    repeat (4) step();

    // reset mid-note
    sel = 0; clear_roms();
    rom_a[0] = ent(7'h66, 1'b0, 8'd4);
    t = cyc + 1;
    push(t + 3, 1'b1, 1'b0, 1'b0, 7'h66);
    start_a = 1'b1; step(); start_a = 1'b0;
    drain("rst_first_on", 10);
    repeat (2) step();
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_mid_note", {addr_a, on_a, off_a, done_a, busy_a, note_a}, 64'd0);
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
